// File: rtl/cache_set_ctrl_if.sv
// Shared MESI state type and the request/bus/response bundle for cache_set_ctrl.
// slave is the controller side; master is the requester/bus-model side.
package cache_set_ctrl_pkg;
  typedef enum logic [1:0] {
    MESI_I = 2'd0,
    MESI_S = 2'd1,
    MESI_E = 2'd2,
    MESI_M = 2'd3
  } states_t;
endpackage

interface cache_set_ctrl_if
  import cache_set_ctrl_pkg::*;
#(
  parameter int TAG_W = 12
);
  logic             req_valid;
  logic             req_ready;
  logic [3:0]       req_cmd;
  logic [TAG_W-1:0] req_tag;
  logic             bus_op_valid;
  logic [1:0]       bus_op;
  logic             bus_ready;
  logic [1:0]       snoop_result;
  logic             resp_valid;
  logic             resp_hit;
  logic [1:0]       resp_way;
  states_t          resp_mesi;
  logic [1:0]       resp_snoop;

  modport slave (
    input  req_valid, req_cmd, req_tag, bus_ready, snoop_result,
    output req_ready, bus_op_valid, bus_op,
    output resp_valid, resp_hit, resp_way, resp_mesi, resp_snoop
  );

  modport master (
    output req_valid, req_cmd, req_tag, bus_ready, snoop_result,
    input  req_ready, bus_op_valid, bus_op,
    input  resp_valid, resp_hit, resp_way, resp_mesi, resp_snoop
  );
endinterface

// File: rtl/cache_set_ctrl.sv
// One 4-way MESI cache set with tree PLRU, serving local and snoop trace commands.
// Define CACHE_SET_CTRL_TRACE_EN to print every MESI transition in simulation.
module cache_set_ctrl
  import cache_set_ctrl_pkg::*;
#(
  parameter int WAYS  = 4,
  parameter int TAG_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  cache_set_ctrl_if.slave  io
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_WB, S_BUS, S_UPDATE, S_RESP
  } fsm_t;

  localparam logic [1:0] OP_READ  = 2'd0;
  localparam logic [1:0] OP_WRITE = 2'd1;
  localparam logic [1:0] OP_INV   = 2'd2;
  localparam logic [1:0] OP_RWIM  = 2'd3;
  localparam logic [1:0] SN_NOHIT = 2'd0;
  localparam logic [1:0] SN_HIT   = 2'd1;
  localparam logic [1:0] SN_HITM  = 2'd2;

  fsm_t             state_q, state_d;
  logic [3:0]       cmd_q, cmd_d;
  logic [TAG_W-1:0] ctag_q, ctag_d;
  logic             hit_q, hit_d;
  logic [1:0]       way_q, way_d;
  logic [1:0]       snp_q, snp_d;
  logic [2:0]       plru_q, plru_d;
  logic [TAG_W-1:0] tags_q [WAYS];
  logic [TAG_W-1:0] tags_d [WAYS];
  states_t          mesi_q [WAYS];
  states_t          mesi_d [WAYS];
  logic             resp_hit_q, resp_hit_d;
  logic [1:0]       resp_way_q, resp_way_d;
  states_t          resp_mesi_q, resp_mesi_d;
  logic [1:0]       resp_snoop_q, resp_snoop_d;

  logic       lk_hit, has_free, is_local, is_snoop;
  logic [1:0] lk_way, free_way, victim;
  states_t    new_mesi;
  logic [1:0] reply;

  // PLRU bits point at the victim side: bit0 picks the half, bit1/bit2 the way within it.
  function automatic logic [2:0] plru_touch(input logic [2:0] p, input logic [1:0] w);
    logic [2:0] r;
    r    = p;
    r[0] = ~w[1];
    if (!w[1]) r[1] = ~w[0];
    else       r[2] = ~w[0];
    return r;
  endfunction

  assign is_local = (cmd_q <= 4'd2);
  assign is_snoop = (cmd_q >= 4'd3) && (cmd_q <= 4'd6);
  assign victim   = has_free ? free_way : (plru_q[0] ? {1'b1, plru_q[2]} : {1'b0, plru_q[1]});

  always_comb begin
    lk_hit   = 1'b0;
    lk_way   = 2'd0;
    has_free = 1'b0;
    free_way = 2'd0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (mesi_q[i] != MESI_I && tags_q[i] == ctag_q) begin
        lk_hit = 1'b1;
        lk_way = 2'(i);
      end
      if (mesi_q[i] == MESI_I) begin
        has_free = 1'b1;
        free_way = 2'(i);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    ctag_d       = ctag_q;
    hit_d        = hit_q;
    way_d        = way_q;
    snp_d        = snp_q;
    plru_d       = plru_q;
    tags_d       = tags_q;
    mesi_d       = mesi_q;
    resp_hit_d   = resp_hit_q;
    resp_way_d   = resp_way_q;
    resp_mesi_d  = resp_mesi_q;
    resp_snoop_d = resp_snoop_q;
    new_mesi     = MESI_I;
    reply        = SN_NOHIT;
    io.req_ready    = 1'b0;
    io.bus_op_valid = 1'b0;
    io.bus_op       = OP_READ;
    io.resp_valid   = 1'b0;

    case (state_q)
      S_IDLE: begin
        io.req_ready = 1'b1;
        if (io.req_valid) begin
          cmd_d   = io.req_cmd;
          ctag_d  = io.req_tag;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        hit_d = lk_hit;
        if (cmd_q == 4'd8) begin
          for (int i = 0; i < WAYS; i++) mesi_d[i] = MESI_I;
          plru_d       = 3'b000;
          resp_hit_d   = 1'b0;
          resp_way_d   = 2'd0;
          resp_mesi_d  = MESI_I;
          resp_snoop_d = SN_NOHIT;
          state_d      = S_RESP;
        end else if (is_local) begin
          if (lk_hit) begin
            way_d   = lk_way;
            state_d = (cmd_q == 4'd1 && mesi_q[lk_way] == MESI_S) ? S_BUS : S_UPDATE;
          end else begin
            way_d   = victim;
            state_d = (mesi_q[victim] == MESI_M) ? S_WB : S_BUS;
          end
        end else if (is_snoop) begin
          way_d   = lk_way;
          state_d = S_UPDATE;
        end else begin
          resp_hit_d   = 1'b0;
          resp_way_d   = 2'd0;
          resp_mesi_d  = mesi_q[0];
          resp_snoop_d = SN_NOHIT;
          state_d      = S_RESP;
        end
      end
      S_WB: begin
        io.bus_op_valid = 1'b1;
        io.bus_op       = OP_WRITE;
        if (io.bus_ready) state_d = S_BUS;
      end
      S_BUS: begin
        io.bus_op_valid = 1'b1;
        io.bus_op       = (cmd_q == 4'd1) ? (hit_q ? OP_INV : OP_RWIM) : OP_READ;
        if (io.bus_ready) begin
          snp_d   = io.snoop_result;
          state_d = S_UPDATE;
        end
      end
      S_UPDATE: begin
        if (is_local) begin
          if (!hit_q) begin
            tags_d[way_q] = ctag_q;
            if (cmd_q == 4'd1)                             new_mesi = MESI_M;
            else if (snp_q == SN_HIT || snp_q == SN_HITM)  new_mesi = MESI_S;
            else                                           new_mesi = MESI_E;
          end else begin
            new_mesi = (cmd_q == 4'd1) ? MESI_M : mesi_q[way_q];
          end
          plru_d = plru_touch(plru_q, way_q);
        end else begin
          new_mesi = mesi_q[way_q];
          if (hit_q) begin
            reply = (mesi_q[way_q] == MESI_M) ? SN_HITM : SN_HIT;
            case (cmd_q)
              4'd3:    if (mesi_q[way_q] == MESI_S) new_mesi = MESI_I;
              4'd4:    new_mesi = MESI_S;
              4'd6:    new_mesi = MESI_I;
              default: new_mesi = mesi_q[way_q];
            endcase
          end
        end
        mesi_d[way_q] = new_mesi;
        resp_hit_d    = hit_q;
        resp_way_d    = way_q;
        resp_mesi_d   = new_mesi;
        resp_snoop_d  = reply;
        state_d       = S_RESP;
      end
      S_RESP: begin
        io.resp_valid = 1'b1;
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign io.resp_hit   = resp_hit_q;
  assign io.resp_way   = resp_way_q;
  assign io.resp_mesi  = resp_mesi_q;
  assign io.resp_snoop = resp_snoop_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cmd_q        <= 4'd0;
      ctag_q       <= '0;
      hit_q        <= 1'b0;
      way_q        <= 2'd0;
      snp_q        <= SN_NOHIT;
      plru_q       <= 3'b000;
      resp_hit_q   <= 1'b0;
      resp_way_q   <= 2'd0;
      resp_mesi_q  <= MESI_I;
      resp_snoop_q <= SN_NOHIT;
      for (int i = 0; i < WAYS; i++) begin
        tags_q[i] <= '0;
        mesi_q[i] <= MESI_I;
      end
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      ctag_q       <= ctag_d;
      hit_q        <= hit_d;
      way_q        <= way_d;
      snp_q        <= snp_d;
      plru_q       <= plru_d;
      resp_hit_q   <= resp_hit_d;
      resp_way_q   <= resp_way_d;
      resp_mesi_q  <= resp_mesi_d;
      resp_snoop_q <= resp_snoop_d;
      tags_q       <= tags_d;
      mesi_q       <= mesi_d;
    end
  end

`ifdef CACHE_SET_CTRL_TRACE_EN
  always @(posedge clk) begin
    for (int i = 0; i < WAYS; i++) begin
      if (rst_n && mesi_d[i] != mesi_q[i])
        $display("cache_set_ctrl: way %0d %s -> %s cmd %0d",
                 i, mesi_q[i].name(), mesi_d[i].name(), cmd_q);
    end
  end
`else
`endif

endmodule

// File: tb/tb_cache_set_ctrl.sv
// Directed bench for cache_set_ctrl: a command table with expected responses,
// plus hand sequences for eviction write-back, a stalled bus and reset mid-operation.
module tb_cache_set_ctrl;
  import cache_set_ctrl_pkg::*;

  localparam logic [1:0] OP_RD = 2'd0, OP_WR = 2'd1, OP_INV = 2'd2, OP_RWIM = 2'd3;

  typedef struct {
    logic [3:0]  cmd;
    logic [11:0] tag;
    logic [1:0]  snp;
    int          rdyDly;
    int          expNbus;
    logic [1:0]  expOp0;
    logic [1:0]  expOp1;
    int          expLat;
    logic        expHit;
    logic        chkWay;
    logic [1:0]  expWay;
    states_t     expMesi;
    logic [1:0]  expSnoop;
  } vec_t;

  logic clk;
  logic rst_n;
  int   nChecks = 0;
  int   nFail   = 0;
  vec_t vecs [19];
  vec_t v;

  cache_set_ctrl_if #(.TAG_W(12)) io ();

  cache_set_ctrl #(.WAYS(4), .TAG_W(12)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (io.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyReset(input string lbl);
    rst_n = 1'b0;
    #1;
    checkOutput({lbl, ".req_ready"},    32'(io.req_ready), 1);
    checkOutput({lbl, ".bus_op_valid"}, 32'(io.bus_op_valid), 0);
    checkOutput({lbl, ".bus_op"},       32'(io.bus_op), 0);
    checkOutput({lbl, ".resp_valid"},   32'(io.resp_valid), 0);
    checkOutput({lbl, ".resp_hit"},     32'(io.resp_hit), 0);
    checkOutput({lbl, ".resp_way"},     32'(io.resp_way), 0);
    checkOutput({lbl, ".resp_mesi"},    32'(io.resp_mesi), 32'(MESI_I));
    checkOutput({lbl, ".resp_snoop"},   32'(io.resp_snoop), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Issues one command, answers the bus with an optional stall, then checks the response.
  task automatic applyStimulus(input string lbl, input vec_t t);
    int         lat, nbus, waitc;
    logic [1:0] ops [2];
    logic [1:0] expOp;
    bit         got;
    @(negedge clk);
    checkOutput({lbl, ".req_ready"}, 32'(io.req_ready), 1);
    io.req_valid    = 1'b1;
    io.req_cmd      = t.cmd;
    io.req_tag      = t.tag;
    io.snoop_result = t.snp;
    io.bus_ready    = 1'b0;
    @(posedge clk);
    #1;
    io.req_valid = 1'b0;
    lat = 2; nbus = 0; waitc = 0; got = 0;
    ops[0] = 2'd0; ops[1] = 2'd0;
    while (!got && lat < 100) begin
      if (io.resp_valid) got = 1;
      else begin
        io.bus_ready = 1'b0;
        if (io.bus_op_valid) begin
          expOp = (nbus == 0) ? t.expOp0 : t.expOp1;
          if (waitc < t.rdyDly) begin
            checkOutput($sformatf("%s.bus_op_stable%0d", lbl, waitc), 32'(io.bus_op), 32'(expOp));
            waitc++;
          end else begin
            io.bus_ready = 1'b1;
            if (nbus < 2) ops[nbus] = io.bus_op;
            nbus++;
            waitc = 0;
          end
        end
        @(posedge clk);
        #1;
        io.bus_ready = 1'b0;
        lat++;
      end
    end
    if (!got) begin
      nChecks++;
      nFail++;
      $display("[TB] FAIL %s.timeout: got no resp_valid expected resp_valid within 100 cycles", lbl);
      return;
    end
    if (t.expLat != 0) checkOutput({lbl, ".latency"}, 32'(lat), 32'(t.expLat));
    checkOutput({lbl, ".bus_ops"}, 32'(nbus), 32'(t.expNbus));
    if (t.expNbus > 0) checkOutput({lbl, ".op0"}, 32'(ops[0]), 32'(t.expOp0));
    if (t.expNbus > 1) checkOutput({lbl, ".op1"}, 32'(ops[1]), 32'(t.expOp1));
    checkOutput({lbl, ".resp_hit"},   32'(io.resp_hit), 32'(t.expHit));
    checkOutput({lbl, ".resp_snoop"}, 32'(io.resp_snoop), 32'(t.expSnoop));
    if (t.chkWay) begin
      checkOutput({lbl, ".resp_way"},  32'(io.resp_way), 32'(t.expWay));
      checkOutput({lbl, ".resp_mesi"}, 32'(io.resp_mesi), 32'(t.expMesi));
    end
    @(posedge clk);
    #1;
    checkOutput({lbl, ".resp_pulse"}, 32'(io.resp_valid), 0);
    checkOutput({lbl, ".resp_hold"},  32'(io.resp_hit), 32'(t.expHit));
  endtask

  initial begin
    bit seen;
    rst_n           = 1'b0;
    io.req_valid    = 1'b0;
    io.req_cmd      = 4'd0;
    io.req_tag      = 12'd0;
    io.bus_ready    = 1'b0;
    io.snoop_result = 2'd0;

    //          cmd   tag      snp  dly nb op0      op1    lat hit chk way mesi    snoop
    vecs[0]  = '{4'd0, 12'h123, 2'd0, 0, 1, OP_RD,   OP_RD, 5, 1'b0, 1'b1, 2'd0, MESI_E, 2'd0};
    vecs[1]  = '{4'd1, 12'h123, 2'd0, 0, 0, OP_RD,   OP_RD, 4, 1'b1, 1'b1, 2'd0, MESI_M, 2'd0};
    vecs[2]  = '{4'd0, 12'h200, 2'd1, 0, 1, OP_RD,   OP_RD, 5, 1'b0, 1'b1, 2'd1, MESI_S, 2'd0};
    vecs[3]  = '{4'd2, 12'h300, 2'd2, 0, 1, OP_RD,   OP_RD, 5, 1'b0, 1'b1, 2'd2, MESI_S, 2'd0};
    vecs[4]  = '{4'd1, 12'h200, 2'd0, 0, 1, OP_INV,  OP_RD, 5, 1'b1, 1'b1, 2'd1, MESI_M, 2'd0};
    vecs[5]  = '{4'd1, 12'h400, 2'd0, 0, 1, OP_RWIM, OP_RD, 5, 1'b0, 1'b1, 2'd3, MESI_M, 2'd0};
    vecs[6]  = '{4'd4, 12'h300, 2'd0, 0, 0, OP_RD,   OP_RD, 4, 1'b1, 1'b1, 2'd2, MESI_S, 2'd1};
    vecs[7]  = '{4'd4, 12'h123, 2'd0, 0, 0, OP_RD,   OP_RD, 4, 1'b1, 1'b1, 2'd0, MESI_S, 2'd2};
    vecs[8]  = '{4'd3, 12'h123, 2'd0, 0, 0, OP_RD,   OP_RD, 4, 1'b1, 1'b1, 2'd0, MESI_I, 2'd1};
    vecs[9]  = '{4'd0, 12'h500, 2'd0, 0, 1, OP_RD,   OP_RD, 5, 1'b0, 1'b1, 2'd0, MESI_E, 2'd0};
    vecs[10] = '{4'd4, 12'h500, 2'd0, 0, 0, OP_RD,   OP_RD, 4, 1'b1, 1'b1, 2'd0, MESI_S, 2'd1};
    vecs[11] = '{4'd6, 12'h500, 2'd0, 0, 0, OP_RD,   OP_RD, 4, 1'b1, 1'b1, 2'd0, MESI_I, 2'd1};
    vecs[12] = '{4'd6, 12'h200, 2'd0, 0, 0, OP_RD,   OP_RD, 4, 1'b1, 1'b1, 2'd1, MESI_I, 2'd2};
    vecs[13] = '{4'd3, 12'h999, 2'd0, 0, 0, OP_RD,   OP_RD, 4, 1'b0, 1'b0, 2'd0, MESI_I, 2'd0};
    vecs[14] = '{4'd0, 12'h300, 2'd0, 0, 0, OP_RD,   OP_RD, 4, 1'b1, 1'b1, 2'd2, MESI_S, 2'd0};
    vecs[15] = '{4'd7, 12'h300, 2'd0, 0, 0, OP_RD,   OP_RD, 0, 1'b0, 1'b0, 2'd0, MESI_I, 2'd0};
    vecs[16] = '{4'd0, 12'h300, 2'd0, 0, 0, OP_RD,   OP_RD, 4, 1'b1, 1'b1, 2'd2, MESI_S, 2'd0};
    vecs[17] = '{4'd8, 12'h000, 2'd0, 0, 0, OP_RD,   OP_RD, 0, 1'b0, 1'b0, 2'd0, MESI_I, 2'd0};
    vecs[18] = '{4'd0, 12'h300, 2'd0, 0, 1, OP_RD,   OP_RD, 5, 1'b0, 1'b1, 2'd0, MESI_E, 2'd0};

    applyReset("reset0");
    for (int i = 0; i < 19; i++) applyStimulus($sformatf("row%0d", i), vecs[i]);

    // Fill all ways with modified lines, then a read miss must evict PLRU way 0.
    applyReset("reset1");
    for (int i = 0; i < 4; i++) begin
      v = '{4'd1, 12'(i + 1), 2'd0, 0, 1, OP_RWIM, OP_RD, 5, 1'b0, 1'b1, 2'(i), MESI_M, 2'd0};
      applyStimulus($sformatf("fill%0d", i), v);
    end
    v = '{4'd0, 12'h005, 2'd0, 0, 2, OP_WR, OP_RD, 6, 1'b0, 1'b1, 2'd0, MESI_E, 2'd0};
    applyStimulus("evict", v);
    v = '{4'd4, 12'h001, 2'd0, 0, 0, OP_RD, OP_RD, 4, 1'b0, 1'b0, 2'd0, MESI_I, 2'd0};
    applyStimulus("evicted_gone", v);

    // Shared line upgraded by a write while the bus stalls for five cycles.
    applyReset("reset2");
    v = '{4'd0, 12'h0AB, 2'd1, 0, 1, OP_RD, OP_RD, 5, 1'b0, 1'b1, 2'd0, MESI_S, 2'd0};
    applyStimulus("shared", v);
    v = '{4'd1, 12'h0AB, 2'd0, 5, 1, OP_INV, OP_RD, 10, 1'b1, 1'b1, 2'd0, MESI_M, 2'd0};
    applyStimulus("upgrade_stall", v);

    // Reset while the write-back waits on the bus.
    applyReset("reset3");
    for (int i = 0; i < 4; i++) begin
      v = '{4'd1, 12'(i + 1), 2'd0, 0, 1, OP_RWIM, OP_RD, 5, 1'b0, 1'b1, 2'(i), MESI_M, 2'd0};
      applyStimulus($sformatf("refill%0d", i), v);
    end
    @(negedge clk);
    io.req_valid    = 1'b1;
    io.req_cmd      = 4'd0;
    io.req_tag      = 12'h005;
    io.snoop_result = 2'd0;
    io.bus_ready    = 1'b0;
    @(posedge clk);
    #1;
    io.req_valid = 1'b0;
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      if (io.bus_op_valid) seen = 1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    checkOutput("wb_wait.valid", 32'(seen), 1);
    checkOutput("wb_wait.op",    32'(io.bus_op), 32'(OP_WR));
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst.bus_op_valid", 32'(io.bus_op_valid), 0);
    checkOutput("midrst.req_ready",    32'(io.req_ready), 1);
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("midrst.resp_valid%0d", k), 32'(io.resp_valid), 0);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    rst_n = 1'b1;
    v = '{4'd0, 12'h001, 2'd0, 0, 1, OP_RD, OP_RD, 5, 1'b0, 1'b1, 2'd0, MESI_E, 2'd0};
    applyStimulus("after_rst", v);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/cache_set_ctrl.md
CACHE_SET_CTRL -- requirements
Module: cache_set_ctrl

Interface
REQ-001 SHALL have parameter WAYS, default 4, meaning ways per set; supported value is 4 only.
REQ-002 SHALL have parameter TAG_W, default 12, meaning tag width in bits.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on posedge clk.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port req_valid  input  1  command present.
REQ-006 SHALL have port req_ready  output  1  controller idle; accepts command.
REQ-007 SHALL have port req_cmd  input  4  trace command n: 0 read, 1 write, 2 ifetch, 3 snoop-invalidate, 4 snoop-read, 5 snoop-write, 6 snoop-RFO, 8 clear.
REQ-008 SHALL have port req_tag  input  TAG_W  address tag.
REQ-009 SHALL have port bus_op_valid  output  1  bus operation requested.
REQ-010 SHALL have port bus_op  output  2  operation: 0 READ, 1 WRITE, 2 INVALIDATE, 3 RWIM.
REQ-011 SHALL have port bus_ready  input  1  bus accepts op this cycle.
REQ-012 SHALL have port snoop_result  input  2  sampled with bus_ready: 0 NOHIT, 1 HIT, 2 HITM.
REQ-013 SHALL have port resp_valid  output  1  one-cycle completion pulse.
REQ-014 SHALL have port resp_hit  output  1  tag hit in a non-I way.
REQ-015 SHALL have port resp_way  output  2  way used.
REQ-016 SHALL have port resp_mesi  output  2 (states_t)  final MESI state of resp_way.
REQ-017 SHALL have port resp_snoop  output  2  snoop reply to other caches: 0 NOHIT, 1 HIT, 2 HITM.

Function
REQ-018 SHALL hold per way: tag, MESI state (states_t); plus a 3-bit tree PLRU for the set.
REQ-019 SHALL implement states IDLE, LOOKUP, WB, BUS, UPDATE, RESP.
REQ-020 IDLE: req_ready=1; on req_valid, SHALL capture cmd/tag and go to LOOKUP; req_ready=0 in every other state.
REQ-021 LOOKUP (1 cycle): hit = tag match in a non-I way; cmd 8 SHALL set all ways I, PLRU=000 and go to RESP.
REQ-022 Local miss (cmd 0/1/2): victim = lowest-index I way, else PLRU victim; victim M -> WB, else -> BUS.
REQ-023 Local hit: cmd 1 on S -> BUS with INVALIDATE; all other local hits -> UPDATE with no bus op.
REQ-024 Snoop cmds (3-6) SHALL never issue a bus op; go to UPDATE.
REQ-025 WB: bus_op_valid=1, bus_op=WRITE, held stable until bus_ready, then -> BUS.
REQ-026 BUS: bus_op = READ (cmd 0/2), RWIM (cmd 1 miss) or INVALIDATE (cmd 1 hit-S), held until bus_ready; snoop_result latched on that cycle; then -> UPDATE.
REQ-027 UPDATE local: read/ifetch miss -> S if HIT/HITM else E; write -> M; E write hit -> M; other hits unchanged; tag written on miss; PLRU touched to make the way MRU.
REQ-028 UPDATE snoop: cmd 4: M->S (HITM), E->S (HIT), S->S (HIT); cmd 3: S->I; cmd 6: M->I (HITM), E/S->I (HIT); cmd 5: no change; miss -> NOHIT; PLRU untouched.
REQ-029 RESP: resp_valid=1 for exactly one cycle with resp_* stable, then -> IDLE; resp_* outside RESP hold last value.
REQ-030 Latency: hit = 4 cycles from acceptance to resp_valid; each bus op adds cycles until bus_ready.
REQ-031 Undefined cmd values SHALL complete as a no-op with resp_hit=0 and resp_snoop=NOHIT.

Reset
REQ-032 On rst_n low, immediately: all ways I, tags 0, PLRU 000, state IDLE, bus_op_valid=0, bus_op=0, resp_valid=0, resp_* = 0/I, req_ready=1.
REQ-033 Reset mid-operation SHALL abort the command with no response; bus_op_valid SHALL drop asynchronously.

Configuration
REQ-034 With CACHE_SET_CTRL_TRACE_EN defined, every MESI change SHALL $display way, old state, new state and cmd; without it, no display output and identical cycle behaviour.

Verification
REQ-035 Reset, cmd 0 tag 0x123, bus_ready same cycle, NOHIT -> bus READ, resp_hit=0, way 0, mesi E.
REQ-036 Then cmd 1 tag 0x123 -> no bus op, resp_hit=1, mesi M, resp_valid 4 cycles after acceptance.
REQ-037 Fill ways 0-3 with tags 1-4 as M, then cmd 0 tag 5 -> WRITE then READ on bus, PLRU victim way 0 replaced.
REQ-038 Line E, cmd 4 same tag -> resp_snoop=HIT, mesi S; then cmd 6 -> mesi I, resp_snoop=HIT.
REQ-039 Line S, cmd 1 -> bus INVALIDATE, mesi M; bus_ready held low 5 cycles -> bus_op stable throughout.
REQ-040 rst_n low during WB wait -> bus_op_valid 0 immediately, no resp_valid, next cmd 0 misses.
